// File: rtl/seq_mult_hs_pkg.sv
// Shared definitions for the handshaked sequential multiplier: mode encodings,
// FSM state type and a constant-evaluable clog2.
package seq_mult_hs_pkg;

   localparam logic [1:0] MODE_UU = 2'b00;
   localparam logic [1:0] MODE_SS = 2'b01;
   localparam logic [1:0] MODE_SU = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/seq_mult_hs_pp.sv
// Combinational partial product of a magnitude and one DIGIT-bit slice of the
// multiplier, built as a shift-add chain so the FSM stays DIGIT-agnostic.
module mult_digit_pp
   import seq_mult_hs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic [WIDTH-1:0]       mag_x_i,
   input  logic [DIGIT-1:0]       digit_i,
   output logic [WIDTH+DIGIT-1:0] pp_o
);

   logic [WIDTH+DIGIT-1:0] x_ext;

   assign x_ext = {{DIGIT{1'b0}}, mag_x_i};

   always_comb begin
      pp_o = '0;
      for (int i = 0; i < DIGIT; i++) begin
         if (digit_i[i]) pp_o = pp_o + (x_ext << i);
      end
   end

endmodule

// File: rtl/seq_mult_hs.sv
// Multi-cycle signed/unsigned multiplier, DIGIT multiplier bits per cycle,
// with valid/ready on both sides and a tag carried alongside the operands.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | accumulating one partial product per cycle, STEPS cycles
// FIX   | apply sign to the magnitude and register prod/tag_out
// DONE  | result presented, out_valid high until out_ready
module seq_mult_hs
   import seq_mult_hs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic [TAG_W-1:0]   tag_out
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = clog2(STEPS + 1);
   localparam int PW    = 2 * WIDTH;

   if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4)) begin : g_bad_digit
      $fatal(1, "seq_mult_hs: DIGIT must be 1, 2 or 4");
   end
   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_width
      $fatal(1, "seq_mult_hs: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [PW-1:0]      prod_q, prod_d;
   logic [WIDTH-1:0]   mx_q, mx_d;
   logic [WIDTH-1:0]   my_q, my_d;
   logic               neg_q, neg_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [TAG_W-1:0]   tag_out_q, tag_out_d;
   logic               sx, sy, accept, last_step;
   logic [WIDTH+DIGIT-1:0] pp;

   assign sx        = (mode == MODE_SS) || (mode == MODE_SU);
   assign sy        = (mode == MODE_SS);
   assign accept    = in_valid && in_ready && !flush;
   assign last_step = (cnt_q == CW'(STEPS - 1));

   // my_q is shifted down each step, so the current digit is always its LSBs
   mult_digit_pp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_pp (
      .mag_x_i (mx_q),
      .digit_i (my_q[DIGIT-1:0]),
      .pp_o    (pp)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_CALC;
         ST_CALC: if (last_step) state_d = ST_FIX;
         ST_FIX:                 state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mx_d      = mx_q;
      my_d      = my_q;
      neg_d     = neg_q;
      tag_d     = tag_q;
      prod_d    = prod_q;
      tag_out_d = tag_out_q;
      if (accept) begin
         mx_d  = (sx && x[WIDTH-1]) ? -x : x;
         my_d  = (sy && y[WIDTH-1]) ? -y : y;
         neg_d = (sx & x[WIDTH-1]) ^ (sy & y[WIDTH-1]);
         tag_d = tag_in;
         cnt_d = '0;
         acc_d = '0;
      end else if (state_q == ST_CALC) begin
         acc_d = acc_q + (PW'(pp) << (cnt_q * DIGIT));
         my_d  = my_q >> DIGIT;
         cnt_d = cnt_q + 1'b1;
      end else if (state_q == ST_FIX && !flush) begin
         prod_d    = neg_q ? -acc_q : acc_q;
         tag_out_d = tag_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         mx_q      <= '0;
         my_q      <= '0;
         neg_q     <= 1'b0;
         tag_q     <= '0;
         prod_q    <= '0;
         tag_out_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mx_q      <= mx_d;
         my_q      <= my_d;
         neg_q     <= neg_d;
         tag_q     <= tag_d;
         prod_q    <= prod_d;
         tag_out_q <= tag_out_d;
      end
   end

   assign prod    = prod_q;
   assign tag_out = tag_out_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed-vector and corner-sequence bench for seq_mult_hs at three
// WIDTH/DIGIT points: (32,1), (8,2), (16,4).
module tb_seq_mult_hs;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [2:0]  iv, fl, ordy;
   logic [1:0]  md  [3];
   logic [3:0]  tgi [3];
   logic [31:0] x0, y0;
   logic [7:0]  x1, y1;
   logic [15:0] x2, y2;
   logic        ir0, ir1, ir2, ov0, ov1, ov2;
   logic [63:0] p0;
   logic [15:0] p1;
   logic [31:0] p2;
   logic [3:0]  to0, to1, to2;

   int total = 0;
   int bad   = 0;

   seq_mult_hs #(.WIDTH(32), .DIGIT(1), .TAG_W(4)) u_d0 (
      .clk(clk), .rstn(rstn), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
      .mode(md[0]), .x(x0), .y(y0), .tag_in(tgi[0]), .out_valid(ov0),
      .out_ready(ordy[0]), .prod(p0), .tag_out(to0));

   seq_mult_hs #(.WIDTH(8), .DIGIT(2), .TAG_W(4)) u_d1 (
      .clk(clk), .rstn(rstn), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
      .mode(md[1]), .x(x1), .y(y1), .tag_in(tgi[1]), .out_valid(ov1),
      .out_ready(ordy[1]), .prod(p1), .tag_out(to1));

   seq_mult_hs #(.WIDTH(16), .DIGIT(4), .TAG_W(4)) u_d2 (
      .clk(clk), .rstn(rstn), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir2),
      .mode(md[2]), .x(x2), .y(y2), .tag_in(tgi[2]), .out_valid(ov2),
      .out_ready(ordy[2]), .prod(p2), .tag_out(to2));

   typedef struct {
      int          d;
      logic [1:0]  m;
      logic [31:0] xv;
      logic [31:0] yv;
      logic [3:0]  t;
      logic [63:0] e;
   } vec_t;

   vec_t vt [$];

   function automatic int width_of(input int d);
      case (d)
         0:       return 32;
         1:       return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int steps_of(input int d);
      case (d)
         0:       return 32;
         default: return 4;
      endcase
   endfunction

   function automatic logic get_ir(input int d);
      case (d)
         0:       return ir0;
         1:       return ir1;
         default: return ir2;
      endcase
   endfunction

   function automatic logic get_ov(input int d);
      case (d)
         0:       return ov0;
         1:       return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic [63:0] get_prod(input int d);
      case (d)
         0:       return p0;
         1:       return {48'd0, p1};
         default: return {32'd0, p2};
      endcase
   endfunction

   function automatic logic [3:0] get_tag(input int d);
      case (d)
         0:       return to0;
         1:       return to1;
         default: return to2;
      endcase
   endfunction

   // Reference: sign-extend per mode and use native 64-bit multiplication.
   function automatic logic [63:0] ref_prod(input int w, input logic [1:0] m,
                                            input logic [31:0] xv, input logic [31:0] yv);
      logic signed [63:0] xs, ys, p;
      logic [63:0] msk, pmsk;
      logic sxx, syy;
      sxx  = (m == 2'b01) || (m == 2'b10);
      syy  = (m == 2'b01);
      msk  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      pmsk = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      xs = $signed({32'd0, xv} & msk);
      ys = $signed({32'd0, yv} & msk);
      if (sxx && xv[w-1]) xs = xs - $signed(64'd1 << w);
      if (syy && yv[w-1]) ys = ys - $signed(64'd1 << w);
      p = xs * ys;
      return p & pmsk;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int d, input logic [1:0] m, input logic [31:0] xv,
                          input logic [31:0] yv, input logic [3:0] t);
      md[d]  = m;
      tgi[d] = t;
      case (d)
         0: begin x0 = xv;       y0 = yv;       end
         1: begin x1 = xv[7:0];  y1 = yv[7:0];  end
         default: begin x2 = xv[15:0]; y2 = yv[15:0]; end
      endcase
   endtask

   task automatic start(input string nm, input int d, input logic [1:0] m,
                        input logic [31:0] xv, input logic [31:0] yv, input logic [3:0] t);
      set_ops(d, m, xv, yv, t);
      iv[d] = 1'b1;
      chk({nm, "/in_ready_pre"}, 64'(get_ir(d)), 64'd1);
      tick();
      iv[d] = 1'b0;
      chk({nm, "/in_ready_busy"}, 64'(get_ir(d)), 64'd0);
   endtask

   task automatic wait_done(input int d, output int n);
      n = 0;
      while (!get_ov(d) && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string nm, input int d, input logic [1:0] m,
                         input logic [31:0] xv, input logic [31:0] yv,
                         input logic [3:0] t, input logic [63:0] e);
      int n;
      start(nm, d, m, xv, yv, t);
      wait_done(d, n);
      chk({nm, "/latency"}, 64'(n), 64'(steps_of(d) + 1));
      chk({nm, "/prod"}, get_prod(d), e);
      chk({nm, "/tag"}, 64'(get_tag(d)), 64'(t));
      ordy[d] = 1'b1;
      tick();
      ordy[d] = 1'b0;
      chk({nm, "/in_ready_ret"}, 64'(get_ir(d)), 64'd1);
      chk({nm, "/out_valid_clr"}, 64'(get_ov(d)), 64'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] rx, ry, msk;
      logic [1:0]  rm;
      logic [3:0]  rt;

      rstn = 1'b0;
      iv   = '0;
      fl   = '0;
      ordy = '0;
      for (int d = 0; d < 3; d++) set_ops(d, 2'b00, 32'd0, 32'd0, 4'd0);

      vt.push_back('{0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 64'hFFFF_FFFE_0000_0001});
      vt.push_back('{0, 2'b00, 32'd3,         32'd4,         4'd1, 64'd12});
      vt.push_back('{0, 2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 4'd2, 64'hC000_0000_8000_0000});
      vt.push_back('{0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 64'hFFFF_FFFF_0000_0001});
      vt.push_back('{0, 2'b00, 32'h8000_0000, 32'd2,         4'd4, 64'h0000_0001_0000_0000});
      vt.push_back('{1, 2'b01, 32'h80,        32'h80,        4'd6, 64'h4000});
      vt.push_back('{1, 2'b01, 32'hFD,        32'h07,        4'd7, 64'hFFEB});
      vt.push_back('{1, 2'b01, 32'h00,        32'hFF,        4'd8, 64'h0000});
      vt.push_back('{1, 2'b10, 32'hFF,        32'hFF,        4'd9, 64'hFF01});
      vt.push_back('{1, 2'b11, 32'hFF,        32'hFF,        4'hA, 64'hFE01});
      vt.push_back('{1, 2'b00, 32'h80,        32'h80,        4'hB, 64'h4000});
      vt.push_back('{1, 2'b10, 32'h80,        32'h02,        4'hC, 64'hFF00});
      vt.push_back('{1, 2'b01, 32'h7F,        32'h80,        4'hD, 64'hC080});
      vt.push_back('{2, 2'b01, 32'h8000,      32'h8000,      4'hE, 64'h4000_0000});
      vt.push_back('{2, 2'b00, 32'h1234,      32'h0010,      4'hF, 64'h0001_2340});
      vt.push_back('{2, 2'b01, 32'hFFFF,      32'h0001,      4'd1, 64'hFFFF_FFFF});
      vt.push_back('{2, 2'b10, 32'h8000,      32'hFFFF,      4'd2, 64'h8000_8000});

      #12;
      for (int d = 0; d < 3; d++) begin
         chk("reset/in_ready", 64'(get_ir(d)), 64'd1);
         chk("reset/out_valid", 64'(get_ov(d)), 64'd0);
         chk("reset/prod", get_prod(d), 64'd0);
         chk("reset/tag", 64'(get_tag(d)), 64'd0);
      end
      rstn = 1'b1;
      tick();

      foreach (vt[i]) begin
         run_op($sformatf("vec%0d", i), vt[i].d, vt[i].m, vt[i].xv, vt[i].yv, vt[i].t, vt[i].e);
      end

      // backpressure: result must hold while out_ready is low, new input ignored
      start("bp", 1, 2'b01, 32'hFD, 32'h07, 4'd9);
      wait_done(1, n);
      chk("bp/latency", 64'(n), 64'd5);
      for (int k = 0; k < 20; k++) begin
         if (k == 5) begin
            set_ops(1, 2'b00, 32'h11, 32'h22, 4'd2);
            iv[1] = 1'b1;
         end
         tick();
         chk("bp/out_valid", 64'(ov1), 64'd1);
         chk("bp/prod", 64'(p1), 64'hFFEB);
         chk("bp/tag", 64'(to1), 64'd9);
         chk("bp/in_ready", 64'(ir1), 64'd0);
      end
      iv[1]   = 1'b0;
      ordy[1] = 1'b1;
      tick();
      ordy[1] = 1'b0;
      chk("bp/in_ready_ret", 64'(ir1), 64'd1);
      chk("bp/out_valid_clr", 64'(ov1), 64'd0);
      chk("bp/prod_kept", 64'(p1), 64'hFFEB);
      for (int k = 0; k < 8; k++) tick();
      chk("bp/no_ghost_op", 64'(ov1), 64'd0);

      // flush at CALC step 3
      start("fl", 1, 2'b01, 32'h80, 32'h80, 4'd4);
      tick();
      tick();
      fl[1] = 1'b1;
      tick();
      fl[1] = 1'b0;
      chk("fl/in_ready", 64'(ir1), 64'd1);
      chk("fl/out_valid", 64'(ov1), 64'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("fl/no_valid", 64'(ov1), 64'd0);
         chk("fl/prod_kept", 64'(p1), 64'hFFEB);
         chk("fl/tag_kept", 64'(to1), 64'd9);
      end
      run_op("fl_next", 1, 2'b00, 32'd3, 32'd4, 4'd3, 64'd12);

      // flush with in_valid in IDLE: nothing captured
      set_ops(1, 2'b00, 32'd5, 32'd5, 4'd1);
      iv[1] = 1'b1;
      fl[1] = 1'b1;
      tick();
      iv[1] = 1'b0;
      fl[1] = 1'b0;
      chk("flidle/in_ready", 64'(ir1), 64'd1);
      for (int k = 0; k < 7; k++) tick();
      chk("flidle/out_valid", 64'(ov1), 64'd0);
      chk("flidle/prod", 64'(p1), 64'd12);

      // flush together with out_ready in DONE
      start("fldone", 1, 2'b10, 32'hFF, 32'hFF, 4'd6);
      wait_done(1, n);
      chk("fldone/prod", 64'(p1), 64'hFF01);
      fl[1]   = 1'b1;
      ordy[1] = 1'b1;
      tick();
      fl[1]   = 1'b0;
      ordy[1] = 1'b0;
      chk("fldone/out_valid", 64'(ov1), 64'd0);
      chk("fldone/in_ready", 64'(ir1), 64'd1);
      chk("fldone/prod_kept", 64'(p1), 64'hFF01);

      // asynchronous reset pulse mid-CALC
      start("arst", 1, 2'b01, 32'h80, 32'h7F, 4'd7);
      tick();
      #2;
      rstn = 1'b0;
      #1;
      chk("arst/in_ready", 64'(ir1), 64'd1);
      chk("arst/out_valid", 64'(ov1), 64'd0);
      chk("arst/prod", 64'(p1), 64'd0);
      chk("arst/tag", 64'(to1), 64'd0);
      #1;
      rstn = 1'b1;
      tick();
      chk("arst/idle_after", 64'(ov1), 64'd0);
      run_op("arst_next", 1, 2'b01, 32'h80, 32'h7F, 4'd7, 64'hC080);

      // random sweep against the arithmetic reference
      for (int d = 0; d < 3; d++) begin
         msk = (width_of(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_of(d)) - 32'd1);
         for (int k = 0; k < 150; k++) begin
            rx = $urandom() & msk;
            ry = $urandom() & msk;
            rm = 2'($urandom_range(3));
            rt = 4'($urandom_range(15));
            run_op($sformatf("rnd_d%0d_%0d", d, k), d, rm, rx, ry, rt,
                   ref_prod(width_of(d), rm, rx, ry));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_mult_hs.md
# seq_mult_hs

Parametrised multi-cycle integer multiplier with valid/ready handshakes on both sides. It retires DIGIT multiplier bits per cycle and supports unsigned, signed, and mixed-sign operands selected per operation. A tag travels with each operand pair. It sits in the DFT datapath as the shared multiplier behind the twiddle/sample schedulers, and supersedes the single-bit, level-triggered multiplier.

## Interface
- WIDTH, 32, operand width; must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 1, multiplier bits retired per cycle; legal values are 1, 2 and 4.
- TAG_W, 4, width of the opaque tag carried from input to output.
- STEPS (derived localparam), WIDTH/DIGIT.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort of any operation in flight.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- mode  in  2  operand signedness: 00 = x and y unsigned; 01 = both signed; 10 = x signed, y unsigned; 11 is reserved and treated as 00.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- tag_in  in  TAG_W  tag, captured with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- prod  out  2*WIDTH  product, two's complement when either operand is signed.
- tag_out  out  TAG_W  tag of the current result.

## Operation
- State machine has four states:
  - IDLE: in_ready=1. An input handshake (in_valid && in_ready) captures |x|, |y|, neg = (sx&x[MSB]) ^ (sy&y[MSB]), and tag_in, then moves to CALC. cnt is set to 0 and acc to 0.
  - CALC: each cycle, acc += (digit of |y| at cnt) * |x| << (cnt*DIGIT), then cnt++. After STEPS cycles, move to FIX.
  - FIX: prod <= neg ? -acc : acc, tag_out <= captured tag, move to DONE.
  - DONE: out_valid=1. On out_ready, return to IDLE.
- Magnitude path:
  - |v| = v[MSB] ? -v : v, computed only for signed operands, held in WIDTH unsigned bits.
  - The most-negative value, -2^(WIDTH-1), has magnitude 2^(WIDTH-1), which fits.
  - acc is 2*WIDTH bits and cannot overflow: the maximum magnitude is 2^(2*WIDTH) - 2^(WIDTH+1) + 1 for unsigned operands.
- prod and tag_out are registered and change only on the FIX edge. They keep their value after the output handshake until the next FIX.
- flush is sampled every cycle:
  - Returns the block to IDLE and clears out_valid.
  - Discards the operation in flight.
  - Leaves prod and tag_out unchanged.
  - Has priority over every handshake in the same cycle.
- Input is never accepted outside IDLE. in_valid asserted in any other state is ignored and has no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, prod=0, tag_out=0, state=IDLE.
- Reset is asynchronous; deasserting it mid-operation leaves the block in IDLE with no output produced.
- Latency: with the input handshake at edge t0, CALC occupies edges t0+1 through t0+STEPS, FIX is edge t0+STEPS+1, and out_valid is high from that edge onward. The product is therefore ready STEPS+1 cycles after acceptance. Examples: 33 cycles for WIDTH=32, DIGIT=1; 9 cycles for DIGIT=4.
- in_ready deasserts on the edge after acceptance and reasserts on the edge after the output handshake.
- Best-case issue interval is STEPS+3 cycles, reached when out_ready is held high.
- out_valid, prod and tag_out stay stable while out_valid=1 && out_ready=0; this is a required stall property.
- flush together with in_valid in IDLE: the input is not captured and in_ready stays 1.
- flush together with out_ready in DONE: the result is dropped, with the same effect as a completed handshake.

## Structure
- Shared package: mode encodings (MODE_UU, MODE_SS, MODE_SU), the state enum, and a clog2 function.
- Sub-module: mult_digit_pp. It is combinational and takes (|x|, DIGIT-bit digit) to produce a WIDTH+DIGIT-bit partial product. It is implemented as an add-shift tree and keeps the DIGIT generalisation out of the FSM.
- Elaboration checks raise a fatal error on an illegal DIGIT or when WIDTH % DIGIT != 0.

## Test plan
- Unsigned, WIDTH=32, DIGIT=1: x=0xFFFFFFFF, y=0xFFFFFFFF, tag=5 → prod=0xFFFFFFFE00000001 and tag_out=5. out_valid rises exactly 33 cycles after acceptance.
- Signed, WIDTH=8, DIGIT=2: (-128)*(-128) → prod=0x4000. (-3)*7 → prod=0xFFEB. Then 0*(-1) → prod=0x0000, not negative zero.
- Mixed mode 10, WIDTH=8: x=0xFF (-1), y=0xFF (255) → prod=0xFF01, i.e. -255.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. prod, tag_out and out_valid must stay stable, in_ready=0, and a new in_valid is ignored. Releasing out_ready gives one handshake and in_ready=1 on the next cycle.
- flush at CALC step 3, then a new operation 3*4: out_valid never rises for the aborted operation, prod keeps its old value until the new FIX, and the new result is 12.
- Async rstn pulse during CALC: outputs show reset values immediately, and the next operation completes correctly. Sweep DIGIT ∈ {1,2,4} with 10k random operands against a reference model.
